// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and bridge FSM state type
package ahb_pkg;

    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_NONSEQ = 1'b1;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    typedef enum logic {
        RUN  = 1'b0,
        ERR1 = 1'b1
    } ahb_state_e;

endpackage

// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - AHB-Lite initiator: request interface to pipelined single NONSEQ transfers
module ahb_master
    import ahb_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [2:0]  HSIZE      = HSIZE_WORD
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err,
    output logic                  o_htrans,
    output logic [2:0]            o_hsize,
    output logic                  o_hwrite,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic [DATA_WIDTH-1:0] o_hwdata,
    output logic                  o_hselx,
    input  logic                  i_hready,
    input  logic                  i_hresp,
    input  logic [DATA_WIDTH-1:0] i_hrdata
);

    ahb_state_e            state_q, state_d;
    logic                  a_vld_q, a_vld_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic                  a_write_q, a_write_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    logic                  d_vld_q, d_vld_d;
    logic                  d_write_q, d_write_d;
    logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;
    logic                  accept;

    assign o_ready = (state_q == RUN) && (i_hready || !a_vld_q);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            state_q   <= RUN;
            a_vld_q   <= 1'b0;
            a_addr_q  <= '0;
            a_write_q <= 1'b0;
            a_wdata_q <= '0;
            d_vld_q   <= 1'b0;
            d_write_q <= 1'b0;
            d_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            a_vld_q   <= a_vld_d;
            a_addr_q  <= a_addr_d;
            a_write_q <= a_write_d;
            a_wdata_q <= a_wdata_d;
            d_vld_q   <= d_vld_d;
            d_write_q <= d_write_d;
            d_wdata_q <= d_wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_vld_d   = a_vld_q;
        a_addr_d  = a_addr_q;
        a_write_d = a_write_q;
        a_wdata_d = a_wdata_q;
        d_vld_d   = d_vld_q;
        d_write_d = d_write_q;
        d_wdata_d = d_wdata_q;
        o_err     = 1'b0;

        case (state_q)
            RUN: begin
                if (d_vld_q && (i_hresp == HRESP_ERROR) && !i_hready) begin
                    // First ERROR cycle: withdraw the pending address phase.
                    state_d = ERR1;
                    a_vld_d = 1'b0;
                end else if (i_hready) begin
                    d_vld_d   = a_vld_q;
                    d_write_d = a_write_q;
                    d_wdata_d = a_wdata_q;
                    a_vld_d   = accept;
                    if (accept) begin
                        a_addr_d  = i_addr;
                        a_write_d = i_rd0_wr1;
                        a_wdata_d = i_wr_data;
                    end
                end else if (accept) begin
                    // Empty A-stage may fill while the data phase waits.
                    a_vld_d   = 1'b1;
                    a_addr_d  = i_addr;
                    a_write_d = i_rd0_wr1;
                    a_wdata_d = i_wr_data;
                end
            end
            ERR1: begin
                if (i_hready) begin
                    o_err   = 1'b1;
                    d_vld_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign o_htrans   = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign o_hselx    = o_htrans;
    assign o_hsize    = HSIZE;
    assign o_hwrite   = a_write_q;
    assign o_haddr    = a_addr_q;
    assign o_hwdata   = (d_vld_q && (d_write_q == WR)) ? d_wdata_q : '0;
    assign o_rd_valid = d_vld_q && (d_write_q == RD) && i_hready && (i_hresp == HRESP_OKAY);
    assign o_rd_data  = o_rd_valid ? i_hrdata : '0;

endmodule

// File: doc/ahb_master.md
Name: ahb_master

Overview:
- AHB-Lite initiator for the AHB2AHB bridge, at the far end from the bridge's AHB slave front-end.
- Accepts simple request-interface transfers (valid / rd0_wr1 / addr / wr_data) and drives them onto the downstream AHB bus as single NONSEQ transfers.
- Address and data phases are pipelined, so back-to-back requests overlap.
- Returns read data, a ready back-pressure signal, and an error indication to the request side.

Parameters:
- DATA_WIDTH, 32, width of wr_data/hwdata/hrdata.
- ADDR_WIDTH, 32, width of addr/haddr.
- HSIZE, 3'b010, constant transfer size driven on o_hsize.

Ports:
- i_clk_ahb  in  1  AHB clock.
- i_rstn_ahb  in  1  reset, asynchronous, active-low.
- i_valid  in  1  request valid.
- i_rd0_wr1  in  1  request direction: 0 = read, 1 = write.
- i_addr  in  ADDR_WIDTH  request address.
- i_wr_data  in  DATA_WIDTH  write data, sampled together with the request.
- o_ready  out  1  request accepted at the clock edge where i_valid && o_ready.
- o_rd_valid  out  1  read data valid.
- o_rd_data  out  DATA_WIDTH  read data.
- o_err  out  1  one-cycle pulse: the transfer completed with ERROR.
- o_htrans  out  1  1 = NONSEQ, 0 = IDLE.
- o_hsize  out  3  = HSIZE.
- o_hwrite  out  1  address-phase direction.
- o_haddr  out  ADDR_WIDTH  address-phase address.
- o_hwdata  out  DATA_WIDTH  data-phase write data.
- o_hselx  out  1  = o_htrans (point-to-point select).
- i_hready  in  1  bus ready.
- i_hresp  in  1  0 = OKAY, 1 = ERROR.
- i_hrdata  in  DATA_WIDTH  read data.

Behaviour:
- Two register stages:
  - A-stage (a_vld, a_addr, a_write, a_wdata) drives the address phase.
  - D-stage (d_vld, d_write, d_wdata) drives the data phase.
- AHB outputs are derived from the stages:
  - o_htrans = a_vld; o_haddr = a_addr; o_hwrite = a_write.
  - o_hwdata = d_wdata when d_vld && d_write, else 0.
- o_ready = state==RUN && (i_hready || !a_vld), combinational.
- Request accept loads the A-stage: a_vld=1, a_addr=i_addr, a_write=i_rd0_wr1, a_wdata=i_wr_data.
- Edge with i_hready=1 (in RUN):
  - D-stage ← A-stage (d_vld ← a_vld).
  - A-stage ← new accepted request, or a_vld ← 0 if none.
- Edge with i_hready=0: D-stage holds. A-stage holds if a_vld; an empty A-stage may load a new request (IDLE→NONSEQ during wait is legal).
- Latency: request accepted at edge E → address phase cycle E+1 → data phase E+2 (zero wait).
- Read response:
  - o_rd_valid = d_vld && !d_write && i_hready && !i_hresp, combinational.
  - o_rd_data = i_hrdata when o_rd_valid, else 0.
- Write completion needs no response beyond o_ready.
- Full pipelining: back-to-back requests with i_hready=1 give sustained 1 transfer/cycle, and o_ready stays 1.
- FSM states: RUN, ERR1.
  - RUN: if d_vld && i_hresp && !i_hready (first ERROR cycle), then next state ERR1, a_vld ← 0 (pending address phase cancelled, o_htrans=0 in the second cycle), and the request in A-stage is discarded.
  - ERR1: o_ready=0. On i_hready=1: o_err=1 (combinational, this cycle only), d_vld ← 0, next state RUN.
  - i_hresp while d_vld=0 is ignored.
- Direction change (write→read, read→write) needs no bubble; hwdata always belongs to the D-stage.
- Reset (async, any time, mid-transfer included):
  - a_vld=d_vld=0, state=RUN, all registered fields 0.
  - Outputs then: o_htrans=0, o_hselx=0, o_hwrite=0, o_haddr=0, o_hwdata=0, o_rd_valid=0, o_rd_data=0, o_err=0, o_ready=1.
  - In-flight transfers are dropped with no response.
- o_hsize is constant HSIZE, including during reset.

Decomposition:
- Shared package ahb_pkg (also used by the bridge slave): HTRANS_IDLE=1'b0, HTRANS_NONSEQ=1'b1, HRESP_OKAY/HRESP_ERROR, HSIZE_BYTE/HALF/WORD constants, RD=0/WR=1, and the state enum typedef (RUN, ERR1).
- No sub-module: the two pipeline stages plus the 2-state FSM fit in one module.

Test Plan:
- Write, reset then i_valid=1, i_rd0_wr1=1, addr=0x1000, data=0xDEADBEEF, i_hready=1:
  - E+1: o_htrans=1, o_haddr=0x1000, o_hwrite=1.
  - E+2: o_hwdata=0xDEADBEEF, o_htrans=0.
- Read, addr=0x2004, slave i_hrdata=0xA5A50001 in data phase → o_rd_valid=1 for one cycle at E+2 with o_rd_data=0xA5A50001.
- Back-to-back W 0x0 (0x11), R 0x4, W 0x8 (0x33) on consecutive cycles → o_ready always 1; o_haddr 0x0,0x4,0x8 on consecutive cycles; o_hwdata=0x11 overlaps the 0x4 address phase.
- Write 0x10 then read 0x14, i_hready=0 for 3 cycles in the write data phase:
  - o_haddr=0x14, o_htrans=1, o_hwdata held stable.
  - o_ready=0 while A-stage is full.
  - Read completes 1 cycle after i_hready returns.
- Error: read 0x20 then write 0x24 (pipelined); slave drives hresp=1/hready=0, then hresp=1/hready=1:
  - o_htrans=0 in the second error cycle and o_err=1 in the second error cycle.
  - o_rd_valid=0 for 0x20; 0x24 is never issued; o_ready=0 during ERR1.
- Assert i_rstn_ahb low during the address phase of a read → all outputs at reset values immediately; o_ready=1 after release; the next request issues normally.
